// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game sequencer: serve/play/over phases, scores, BCD rally, sound pulses
module pong_game_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 120,
  parameter int OVER_DELAY  = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] btn1,
  input  logic [1:0] btn2,
  input  logic       hit,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       gra_still,
  output logic [2:0] game_state,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [7:0] rally,
  output logic [1:0] winner,
  output logic       snd_hit,
  output logic       snd_miss
);

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

  localparam logic [3:0] WIN      = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LD = 8'(SERVE_DELAY);
  localparam logic [7:0] OVER_LD  = 8'(OVER_DELAY);

  state_t     state;
  logic [7:0] timer;
  logic       any_btn_q;
  logic       any_btn;
  logic       btn_edge;
  logic [3:0] score_l_inc;
  logic [3:0] score_r_inc;

  assign any_btn     = |{btn1, btn2};
  assign btn_edge    = any_btn & ~any_btn_q;
  assign score_l_inc = score_l + 4'd1;
  assign score_r_inc = score_r + 4'd1;
  assign gra_still   = (state != PLAY);
  assign game_state  = {1'b0, state};

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= 8'd0;
      any_btn_q <= 1'b0;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      rally     <= 8'h00;
      winner    <= 2'b00;
      snd_hit   <= 1'b0;
      snd_miss  <= 1'b0;
    end else begin
      any_btn_q <= any_btn;
      snd_hit   <= 1'b0;
      snd_miss  <= 1'b0;
      if (frame_tick && timer != 8'd0) timer <= timer - 8'd1;

      case (state)
        IDLE: begin
          if (btn_edge) begin
            score_l <= 4'd0;
            score_r <= 4'd0;
            rally   <= 8'h00;
            winner  <= 2'b00;
            timer   <= SERVE_LD;
            state   <= SERVE;
          end
        end
        SERVE: begin
          if (frame_tick && timer == 8'd0) state <= PLAY;
        end
        PLAY: begin
          // A miss always takes priority over a same-cycle hit.
          if (miss_l && miss_r) begin
            snd_miss <= 1'b1;
            rally    <= 8'h00;
            timer    <= SERVE_LD;
            state    <= SERVE;
          end else if (miss_l) begin
            snd_miss <= 1'b1;
            score_r  <= score_r_inc;
            if (score_r_inc == WIN) begin
              winner <= 2'b10;
              timer  <= OVER_LD;
              state  <= OVER;
            end else begin
              rally <= 8'h00;
              timer <= SERVE_LD;
              state <= SERVE;
            end
          end else if (miss_r) begin
            snd_miss <= 1'b1;
            score_l  <= score_l_inc;
            if (score_l_inc == WIN) begin
              winner <= 2'b01;
              timer  <= OVER_LD;
              state  <= OVER;
            end else begin
              rally <= 8'h00;
              timer <= SERVE_LD;
              state <= SERVE;
            end
          end else if (hit) begin
            snd_hit <= 1'b1;
            rally   <= bcd_inc(rally);
          end
        end
        OVER: begin
          if (timer == 8'd0 && btn_edge) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed scoreboard bench for pong_game_ctrl
module tb_pong_game_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2, S_OVER = 3'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [1:0] btn1, btn2;
  logic       hit, miss_l, miss_r;
  logic       gra_still;
  logic [2:0] game_state;
  logic [3:0] score_l, score_r;
  logic [7:0] rally;
  logic [1:0] winner;
  logic       snd_hit, snd_miss;

  pong_game_ctrl #(.WIN_SCORE(4), .SERVE_DELAY(2), .OVER_DELAY(2)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn1(btn1), .btn2(btn2),
    .hit(hit), .miss_l(miss_l), .miss_r(miss_r), .gra_still(gra_still),
    .game_state(game_state), .score_l(score_l), .score_r(score_r), .rally(rally),
    .winner(winner), .snd_hit(snd_hit), .snd_miss(snd_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [7:0] rl;
    logic [1:0] win;
    logic       still;
    logic       sh;
    logic       sm;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  logic [2:0] e_st;
  logic [3:0] e_sl, e_sr;
  logic [7:0] e_rally;
  logic [1:0] e_win;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input logic sh, input logic sm);
    q.push_back('{tag, e_st, e_sl, e_sr, e_rally, e_win, (e_st != S_PLAY), sh, sm});
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    assert (q.size() > 0) passed++;
    else $error("FAIL scoreboard_empty observed=0 expected=1");
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp({e.tag, ".state"},    {5'd0, game_state}, {5'd0, e.st});
      cmp({e.tag, ".score_l"},  {4'd0, score_l},    {4'd0, e.sl});
      cmp({e.tag, ".score_r"},  {4'd0, score_r},    {4'd0, e.sr});
      cmp({e.tag, ".rally"},    rally,              e.rl);
      cmp({e.tag, ".winner"},   {6'd0, winner},     {6'd0, e.win});
      cmp({e.tag, ".still"},    {7'd0, gra_still},  {7'd0, e.still});
      cmp({e.tag, ".snd_hit"},  {7'd0, snd_hit},    {7'd0, e.sh});
      cmp({e.tag, ".snd_miss"}, {7'd0, snd_miss},   {7'd0, e.sm});
    end
  endtask

  // Drive one cycle of inputs, record what must be visible after the edge, then check it.
  task automatic drive(input logic [1:0] b1, input logic h, input logic ml, input logic mr,
                       input logic ft, input logic sh, input logic sm, input string tag);
    btn1 = b1; hit = h; miss_l = ml; miss_r = mr; frame_tick = ft;
    push_exp(tag, sh, sm);
    @(posedge clk); #1;
    check_out();
  endtask

  task automatic serve_wait();
    for (int i = 0; i < 3; i++) begin
      repeat (9) drive(2'b00, 0, 0, 0, 0, 0, 0, "serve_wait");
      if (i == 2) e_st = S_PLAY;
      drive(2'b00, 0, 0, 0, 1, 0, 0, "serve_tick");
    end
  endtask

  task automatic set_reset_exp();
    e_st = S_IDLE; e_sl = 4'd0; e_sr = 4'd0; e_rally = 8'h00; e_win = 2'b00;
  endtask

  initial begin
    reset = 1'b1; btn1 = 2'b00; btn2 = 2'b00; hit = 0; miss_l = 0; miss_r = 0; frame_tick = 0;
    set_reset_exp();
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 0, 0);
    check_out();
    reset = 1'b0;

    drive(2'b00, 0, 1, 0, 0, 0, 0, "idle_miss_ignored");
    e_st = S_SERVE;
    drive(2'b01, 0, 0, 0, 0, 0, 0, "press1");
    drive(2'b01, 0, 0, 0, 0, 0, 0, "press2");
    drive(2'b01, 0, 0, 0, 0, 0, 0, "press3");
    drive(2'b00, 1, 0, 0, 0, 0, 0, "serve_hit_ignored");
    serve_wait();

    for (int n = 1; n <= 12; n++) begin
      e_rally = {4'(n / 10), 4'(n % 10)};
      drive(2'b00, 1, 0, 0, 0, 1, 0, "hit");
    end
    e_sr = 4'd1; e_st = S_SERVE; e_rally = 8'h00;
    drive(2'b00, 0, 1, 0, 0, 0, 1, "miss_l");
    serve_wait();

    e_rally = 8'h01;
    drive(2'b00, 1, 0, 0, 0, 1, 0, "hit_one");
    e_sl = 4'd1; e_st = S_SERVE; e_rally = 8'h00;
    drive(2'b00, 1, 0, 1, 0, 0, 1, "miss_r_with_hit");
    serve_wait();
    e_st = S_SERVE;
    drive(2'b00, 0, 1, 1, 0, 0, 1, "void_point");

    for (int s = 2; s <= 3; s++) begin
      serve_wait();
      e_sl = 4'(s); e_st = S_SERVE;
      drive(2'b00, 0, 0, 1, 0, 0, 1, "build_score");
    end
    serve_wait();

    reset = 1'b1; btn1 = 2'b10;
    #1;
    set_reset_exp();
    push_exp("mid_reset", 0, 0);
    check_out();
    @(posedge clk); #1;
    reset = 1'b0;
    e_st = S_SERVE;
    drive(2'b10, 0, 0, 0, 0, 0, 0, "held_through_reset");
    drive(2'b10, 0, 0, 0, 0, 0, 0, "held_no_second_edge");

    for (int s = 1; s <= 4; s++) begin
      serve_wait();
      e_sl = 4'(s);
      if (s == 4) begin e_st = S_OVER; e_win = 2'b01; end
      else e_st = S_SERVE;
      drive(2'b00, 0, 0, 1, 0, 0, 1, "win_race");
    end

    drive(2'b01, 0, 0, 0, 0, 0, 0, "over_press_early");
    drive(2'b00, 0, 0, 0, 1, 0, 0, "over_tick1");
    drive(2'b01, 0, 0, 0, 0, 0, 0, "over_press_mid");
    drive(2'b00, 0, 0, 0, 1, 0, 0, "over_tick2");
    e_st = S_IDLE;
    drive(2'b01, 0, 0, 0, 0, 0, 0, "over_press_late");
    drive(2'b00, 0, 1, 0, 0, 0, 0, "idle_keeps_scores");
    e_st = S_SERVE; e_sl = 4'd0; e_sr = 4'd0; e_win = 2'b00;
    drive(2'b01, 0, 0, 0, 0, 0, 0, "new_match");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
